spi_txn_scheduler: RTL and testbench
====================================

Name: spi_txn_scheduler

Overview:
Shares the single spi_master between NUM_REQ requesters, e.g. the button up/down path and a periodic status poller. It arbitrates pending byte requests round-robin and kicks one master transfer at a time. It waits for completion with a timeout, returns the received byte to the granted requester, and enforces an idle gap between transfers. It sits in top between the request sources and spi_master.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
DATA_W, 8, SPI word width.
TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT before abort (>=2).
GAP_CYCLES, 16, idle cycles after each transaction before next arbitration (0 allowed).

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  per-requester request; level, held until gnt.
req_data  in  NUM_REQ*DATA_W  flattened tx bytes; requester i uses bits [i*DATA_W +: DATA_W].
gnt  out  NUM_REQ  one-hot, one-cycle accept pulse.
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
rsp_data  out  DATA_W  received byte, valid with rsp_valid.
rsp_err  out  1  timeout flag, valid with rsp_valid.
m_start  out  1  one-cycle transfer kick to spi_master. Top level inverts it, because spi_master starts on a low pulse of its reset input.
m_tx_data  out  DATA_W  byte to the master's tx_data.
m_done  in  1  transfer complete (master rx_done), one-cycle pulse.
m_rx_data  in  DATA_W  master's rx_data, valid when m_done=1.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, m_start=0, m_tx_data=0, busy=0. State=IDLE, rr pointer=0 (req[0] highest priority), counters=0.
- States: IDLE, START, WAIT, RESP, GAP.
- IDLE:
  - If req != 0 at cycle T, pick the first set bit scanning from pointer upward, with wrap.
  - Latch the index and req_data slice; go to START.
  - If req == 0, stay in IDLE.
- START (T+1):
  - gnt[idx]=1 and m_start=1 for exactly this cycle.
  - m_tx_data = latched byte.
  - pointer <= (idx+1) mod NUM_REQ. Clear the timeout counter; go to WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - If m_done=1, latch m_rx_data; err=0; go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1, latched data=0; err=1; go to RESP.
  - If m_done and timeout occur in the same cycle, m_done wins (err=0).
- RESP (one cycle): rsp_valid[idx]=1, rsp_data/rsp_err driven from the latched values.
  - If GAP_CYCLES=0, go to IDLE.
  - Else go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait; they are not lost because req is level.
- m_tx_data holds the latched byte from START until the next START.
- rsp_data/rsp_err hold their last value outside RESP.
- m_done outside WAIT is ignored.
- req_data is sampled only in the IDLE arbitration cycle. Later changes do not affect the transfer in flight.
- Latency, no contention: req rises at T -> gnt/m_start at T+1 -> first WAIT cycle T+2 -> m_done at D -> rsp_valid at D+1.
- A requester that drops req before gnt is simply not served. No partial effects occur.
- reset asserted in any state:
  - Next state is IDLE with all outputs at reset values.
  - No rsp is issued for the aborted transfer; m_start is never high in a cycle following reset=1.
- Counter widths are $clog2(TIMEOUT_CYCLES) and $clog2(GAP_CYCLES+1) (min 1). Counters do not wrap within a state.

Decomposition:
- Shared header spi_defs.vh holds state encodings (IDLE=0, START=1, WAIT=2, RESP=3, GAP=4, 3-bit) and the default SPI_DATA_W=8 constant, for reuse by spi_master/spi_slave benches.
- One sub-module rr_arbiter is natural. It takes req, pointer, and an enable, and outputs a one-hot grant plus the binary index. It is purely combinational; the pointer register stays in the scheduler.

Test Plan:
- Single request: req=01, req_data[7:0]=0x2A; model returns m_done 20 cycles after m_start with rx=0xAD. Expect gnt=01 at T+1, m_tx_data=0x2A, rsp_valid=01 with rsp_data=0xAD and rsp_err=0 one cycle after m_done. busy then stays high for GAP_CYCLES cycles.
- Contention: req=11 held continuously, bytes 0x11/0x22. Expect the grant order 01,10,01,10 with m_tx_data 0x11,0x22,0x11,0x22, and no back-to-back START without GAP_CYCLES idle cycles between.
- Timeout: TIMEOUT_CYCLES=64, model never pulses m_done. Expect rsp_valid at m_start+65, rsp_err=1, rsp_data=0x00, then return to IDLE and serve the next request normally.
- Done/timeout collision: model pulses m_done on the last WAIT cycle with rx=0x5C. Expect rsp_err=0 and rsp_data=0x5C.
- Reset mid-transfer: assert reset for one cycle in WAIT, then pulse m_done later. Expect no rsp_valid, all outputs 0, and busy=0 the cycle after reset. The stray m_done is ignored, and the next req=10 is granted first because the pointer is back at 0, so 10 is the only requester.
- GAP_CYCLES=0 build: req=01 held. Expect the next gnt exactly 2 cycles after rsp_valid (RESP->IDLE->START).

Source files
------------

// File: rtl/spi_txn_scheduler_pkg.sv
// Shared definitions for the SPI transaction scheduler: FSM encoding, default
// word width and a width helper used for counters and indices.
package spi_txn_scheduler_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } sched_state_t;

  // $clog2 that never returns 0, so single-value counters still get one bit
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Requester-side and spi_master-side signals of the scheduler, bundled so the
// top level can wire the arbitrated port with a single connection.
interface spi_txn_scheduler_if
  import spi_txn_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = SPI_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      m_start;
  logic [DATA_W-1:0]         m_tx_data;
  logic                      m_done;
  logic [DATA_W-1:0]         m_rx_data;

  modport slave (
    input  req, req_data, m_done, m_rx_data,
    output gnt, rsp_valid, rsp_data, rsp_err, m_start, m_tx_data
  );

  modport master (
    output req, req_data, m_done, m_rx_data,
    input  gnt, rsp_valid, rsp_data, rsp_err, m_start, m_tx_data
  );

endinterface

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// The pointer register itself lives in the scheduler.
module spi_txn_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(ptr) + k) % NUM_REQ;
        if (!valid && req[cand]) begin
          valid       = 1'b1;
          grant[cand] = 1'b1;
          idx         = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one spi_master between NUM_REQ requesters: round-robin arbitration,
// one transfer at a time with timeout, response routing and an idle gap.
module spi_txn_scheduler
  import spi_txn_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = SPI_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 16
) (
  input  logic                clk,
  input  logic                reset,
  spi_txn_scheduler_if.slave  bus,
  output logic                busy
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int TMO_W = clog2_min1(TIMEOUT_CYCLES);
  localparam int GAP_W = clog2_min1(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t        state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_REQ-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [NUM_REQ-1:0]  gnt_c;
  logic [NUM_REQ-1:0]  rsp_valid_c;
  logic                m_start_c;

  spi_txn_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .en    (state_q == S_IDLE),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    err_d       = err_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    gnt_c       = '0;
    rsp_valid_c = '0;
    m_start_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // req_data is captured only here; later changes cannot reach the transfer
        if (arb_valid) begin
          idx_d   = arb_idx;
          sel_d   = arb_grant;
          tx_d    = bus.req_data[arb_idx*DATA_W +: DATA_W];
          state_d = S_START;
        end
      end
      S_START: begin
        gnt_c     = sel_q;
        m_start_c = 1'b1;
        ptr_d     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // a completion on the final wait cycle takes precedence over the timeout
        if (bus.m_done) begin
          rx_d    = bus.m_rx_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rx_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_c = sel_q;
        gap_cnt_d   = '0;
        state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- state register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      sel_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.m_start   = m_start_c;
  assign bus.m_tx_data = tx_q;
  assign bus.rsp_data  = rx_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench: dut_a (TIMEOUT 64, GAP 4) covers arbitration, timeout,
// collision and reset; dut_b (GAP 0) covers back-to-back re-grant timing.
module tb_spi_txn_scheduler;

  typedef struct {
    logic [1:0] vec;
    logic [7:0] data;
    logic       flag;   // expected m_start for grants, expected rsp_err for responses
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic busy_a, busy_b;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   model_delay = 0;
  logic [7:0] model_rx = 8'h00;

  ev_t ga_q[$], ra_q[$], gb_q[$], rb_q[$];
  ev_t ea, eb;

  spi_txn_scheduler_if #(.NUM_REQ(2), .DATA_W(8)) ifa();
  spi_txn_scheduler_if #(.NUM_REQ(2), .DATA_W(8)) ifb();

  spi_txn_scheduler #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYCLES(64), .GAP_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a)
  );

  spi_txn_scheduler #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYCLES(64), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input ev_t e, input logic [1:0] vec,
                        input logic [7:0] data, input logic flag);
    chk({tag, "_vec"},  {30'd0, vec},  {30'd0, e.vec});
    chk({tag, "_data"}, {24'd0, data}, {24'd0, e.data});
    chk({tag, "_flag"}, {31'd0, flag}, {31'd0, e.flag});
    chk({tag, "_cycle"}, cyc, e.cyc);
  endtask

  task automatic unexpected(input string tag, input logic [1:0] vec);
    checks++;
    failures++;
    $display("FAIL %s unexpected pulse at cycle %0d: got vec %0h, expected none", tag, cyc, vec);
  endtask

  task automatic goto_drv(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic goto_smp(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_gnt"},       {30'd0, ifa.gnt},       32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, ifa.rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"},  {24'd0, ifa.rsp_data},  32'd0);
    chk({tag, "_rsp_err"},   {31'd0, ifa.rsp_err},   32'd0);
    chk({tag, "_m_start"},   {31'd0, ifa.m_start},   32'd0);
    chk({tag, "_m_tx_data"}, {24'd0, ifa.m_tx_data}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy_a},        32'd0);
  endtask

  function automatic ev_t mk(input logic [1:0] vec, input logic [7:0] data,
                             input logic flag, input int c);
    ev_t e;
    e.vec = vec; e.data = data; e.flag = flag; e.cyc = c;
    return e;
  endfunction

  // ---- spi_master models ----
  initial begin
    int d;
    logic [7:0] r;
    ifa.m_done = 1'b0;
    ifa.m_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (ifa.m_start && model_delay != 0) begin
        d = model_delay;
        r = model_rx;
        repeat (d) @(posedge clk);
        #2 ifa.m_done = 1'b1; ifa.m_rx_data = r;
        @(posedge clk);
        #2 ifa.m_done = 1'b0; ifa.m_rx_data = 8'h00;
      end
    end
  end

  initial begin
    ifb.m_done = 1'b0;
    ifb.m_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (ifb.m_start) begin
        repeat (4) @(posedge clk);
        #2 ifb.m_done = 1'b1; ifb.m_rx_data = 8'hB4;
        @(posedge clk);
        #2 ifb.m_done = 1'b0; ifb.m_rx_data = 8'h00;
      end
    end
  end

  // ---- monitors ----
  always @(negedge clk) begin
    if (ifa.gnt != 2'b00 || ifa.m_start) begin
      if (ga_q.size() == 0) unexpected("a_gnt", ifa.gnt);
      else begin
        ea = ga_q.pop_front();
        chk_ev("a_gnt", ea, ifa.gnt, ifa.m_tx_data, ifa.m_start);
      end
    end
    if (ifa.rsp_valid != 2'b00) begin
      if (ra_q.size() == 0) unexpected("a_rsp", ifa.rsp_valid);
      else begin
        ea = ra_q.pop_front();
        chk_ev("a_rsp", ea, ifa.rsp_valid, ifa.rsp_data, ifa.rsp_err);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.gnt != 2'b00 || ifb.m_start) begin
      if (gb_q.size() == 0) unexpected("b_gnt", ifb.gnt);
      else begin
        eb = gb_q.pop_front();
        chk_ev("b_gnt", eb, ifb.gnt, ifb.m_tx_data, ifb.m_start);
      end
    end
    if (ifb.rsp_valid != 2'b00) begin
      if (rb_q.size() == 0) unexpected("b_rsp", ifb.rsp_valid);
      else begin
        eb = rb_q.pop_front();
        chk_ev("b_rsp", eb, ifb.rsp_valid, ifb.rsp_data, ifb.rsp_err);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog at cycle %0d: got no completion, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---- stimulus ----
  initial begin
    reset = 1'b1;
    ifa.req = 2'b00; ifa.req_data = 16'h0000;
    ifb.req = 2'b00; ifb.req_data = 16'h0000;
    goto_smp(2);
    check_idle_a("reset");
    chk("reset_busy_b", {31'd0, busy_b}, 32'd0);
    goto_drv(3);
    reset = 1'b0;

    // single request: gnt at T+1, rsp one cycle after m_done, then 4 gap cycles
    goto_drv(5);
    model_delay = 20; model_rx = 8'hAD;
    ifa.req_data = 16'h002A; ifa.req = 2'b01;
    ga_q.push_back(mk(2'b01, 8'h2A, 1'b1, 6));
    ra_q.push_back(mk(2'b01, 8'hAD, 1'b0, 27));
    goto_drv(6);  ifa.req = 2'b00;
    goto_drv(7);  ifa.req_data = 16'h0077;
    goto_smp(31); chk("gap_busy_last", {31'd0, busy_a}, 32'd1);
    goto_smp(32); chk("gap_busy_idle", {31'd0, busy_a}, 32'd0);
    chk("tx_hold", {24'd0, ifa.m_tx_data}, 32'h2A);

    // reset during WAIT: no response, stray m_done ignored, pointer back to 0
    goto_drv(35);
    model_delay = 30; model_rx = 8'hEE;
    ifa.req_data = 16'h0033; ifa.req = 2'b01;
    ga_q.push_back(mk(2'b01, 8'h33, 1'b1, 36));
    goto_drv(36); ifa.req = 2'b00;
    goto_drv(40); reset = 1'b1;
    goto_drv(41); reset = 1'b0;
    goto_smp(41);
    check_idle_a("midreset");

    // contention with both requests held: alternating grants, 12-cycle spacing
    goto_drv(70);
    model_delay = 5; model_rx = 8'hC1;
    ifa.req_data = 16'h2211; ifa.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ga_q.push_back(mk((i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h11 : 8'h22, 1'b1, 71 + 12*i));
      ra_q.push_back(mk((i % 2 == 0) ? 2'b01 : 2'b10, 8'hC1, 1'b0, 77 + 12*i));
    end
    goto_drv(108); ifa.req = 2'b00;

    // timeout: rsp at m_start+65 with err, then a request raised during GAP
    goto_drv(120);
    model_delay = 0;
    ifa.req_data = 16'h6611; ifa.req = 2'b10;
    ga_q.push_back(mk(2'b10, 8'h66, 1'b1, 121));
    ra_q.push_back(mk(2'b10, 8'h00, 1'b1, 186));
    goto_drv(121); ifa.req = 2'b00;
    goto_smp(187); chk("tmo_gap_busy", {31'd0, busy_a}, 32'd1);
    goto_drv(188);
    model_delay = 2; model_rx = 8'h3C;
    ifa.req_data = 16'h665A; ifa.req = 2'b01;
    ga_q.push_back(mk(2'b01, 8'h5A, 1'b1, 192));
    ra_q.push_back(mk(2'b01, 8'h3C, 1'b0, 195));
    goto_smp(190); chk("err_hold", {31'd0, ifa.rsp_err}, 32'd1);
    goto_drv(192); ifa.req = 2'b00;

    // m_done on the final WAIT cycle wins over the timeout
    goto_drv(202);
    model_delay = 64; model_rx = 8'h5C;
    ifa.req_data = 16'h775A; ifa.req = 2'b10;
    ga_q.push_back(mk(2'b10, 8'h77, 1'b1, 203));
    ra_q.push_back(mk(2'b10, 8'h5C, 1'b0, 268));
    goto_drv(203); ifa.req = 2'b00;
    // request withdrawn during GAP must never be granted
    goto_drv(269); ifa.req = 2'b01;
    goto_smp(270);
    chk("rsp_data_hold", {24'd0, ifa.rsp_data}, 32'h5C);
    chk("rsp_err_hold",  {31'd0, ifa.rsp_err},  32'd0);
    goto_drv(271); ifa.req = 2'b00;
    goto_smp(276); chk("drop_busy", {31'd0, busy_a}, 32'd0);

    // GAP_CYCLES=0: next grant exactly 2 cycles after each response
    goto_drv(280);
    ifb.req_data = 16'h000B; ifb.req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      gb_q.push_back(mk(2'b01, 8'h0B, 1'b1, 281 + 7*i));
      rb_q.push_back(mk(2'b01, 8'hB4, 1'b0, 286 + 7*i));
    end
    goto_drv(296); ifb.req = 2'b00;

    goto_smp(310);
    chk("a_gnt_pending", ga_q.size(), 32'd0);
    chk("a_rsp_pending", ra_q.size(), 32'd0);
    chk("b_gnt_pending", gb_q.size(), 32'd0);
    chk("b_rsp_pending", rb_q.size(), 32'd0);
    chk("b_busy_end", {31'd0, busy_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
